// File: rtl/bp_sacc_vsum.sv
// Vector-sum accelerator: CSR slave on the I/O command port, read master walking base+8*idx.
// Latency: CSR response one cycle after accept; next vector read one cycle after each data beat.
// Backpressure: one-entry response register blocks new commands until yumi; one read outstanding.

package bp_sacc_vsum_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef struct packed {
        int paddr_width;
        int cce_block_width;
        int lce_id_width;
        int lce_assoc;
    } bp_proc_param_s;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    // Processor configuration table; only the default configuration exists for this tile.
    function automatic bp_proc_param_s bp_get_proc_param(input bp_params_e cfg);
        bp_proc_param_s p;
        case (cfg)
            e_bp_default_cfg: begin
                p.paddr_width     = 40;
                p.cce_block_width = 64;
                p.lce_id_width    = 4;
                p.lce_assoc       = 8;
            end
            default: begin
                p.paddr_width     = 40;
                p.cce_block_width = 64;
                p.lce_id_width    = 4;
                p.lce_assoc       = 8;
            end
        endcase
        return p;
    endfunction

    // Width of the flattened memory message: msg_type, addr, size, {lce_id, way_id}, data.
    function automatic int bp_mem_msg_width(input bp_params_e cfg);
        bp_proc_param_s p;
        p = bp_get_proc_param(cfg);
        return 4 + p.paddr_width + 3 + p.lce_id_width + $clog2(p.lce_assoc) + p.cce_block_width;
    endfunction

endpackage

module bp_sacc_vsum
    import bp_sacc_vsum_pkg::*;
#(
    parameter bp_params_e     bp_params_p      = e_bp_default_cfg,
    parameter logic [63:0]    csr_base_p       = '0,
    localparam bp_proc_param_s proc_param_lp   = bp_get_proc_param(bp_params_p),
    localparam int            lce_id_width_p   = proc_param_lp.lce_id_width,
    localparam int            mem_msg_width_lp = bp_mem_msg_width(bp_params_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [lce_id_width_p-1:0]   lce_id_i,

    input  logic [mem_msg_width_lp-1:0] io_cmd_i,
    input  logic                        io_cmd_v_i,
    output logic                        io_cmd_ready_o,

    output logic [mem_msg_width_lp-1:0] io_resp_o,
    output logic                        io_resp_v_o,
    input  logic                        io_resp_yumi_i,

    output logic [mem_msg_width_lp-1:0] io_cmd_o,
    output logic                        io_cmd_v_o,
    input  logic                        io_cmd_yumi_i,

    input  logic [mem_msg_width_lp-1:0] io_resp_i,
    input  logic                        io_resp_v_i,
    output logic                        io_resp_ready_o
);

    localparam int paddr_width_p     = proc_param_lp.paddr_width;
    localparam int cce_block_width_p = proc_param_lp.cce_block_width;
    localparam int lce_assoc_p       = proc_param_lp.lce_assoc;
    localparam int way_id_width_lp   = $clog2(lce_assoc_p);

    localparam logic [7:0] csr_base_off_lp   = 8'h00;
    localparam logic [7:0] csr_len_off_lp    = 8'h08;
    localparam logic [7:0] csr_start_off_lp  = 8'h10;
    localparam logic [7:0] csr_status_off_lp = 8'h18;
    localparam logic [7:0] csr_result_off_lp = 8'h20;

    typedef struct packed {
        logic [lce_id_width_p-1:0]  lce_id;
        logic [way_id_width_lp-1:0] way_id;
    } payload_s;

    typedef struct packed {
        bp_bedrock_mem_type_e       msg_type;
        logic [paddr_width_p-1:0]   addr;
        bp_bedrock_msg_size_e       size;
        payload_s                   payload;
    } header_s;

    typedef struct packed {
        header_s                    header;
        logic [cce_block_width_p-1:0] data;
    } msg_s;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_req  = 2'd1,
        e_wait = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] base_q, base_d;
    logic [63:0] len_q, len_d;
    logic [63:0] result_q, result_d;
    logic [63:0] idx_q, idx_d;
    logic        done_q, done_d;
    logic        resp_v_q, resp_v_d;
    msg_s        resp_q, resp_d;

    msg_s        cmd_in;
    msg_s        mem_resp_in;
    msg_s        rd_cmd;
    logic [7:0]  csr_off;
    logic        cmd_acc;
    logic        cmd_is_wr;
    logic        busy;
    logic        start_go;
    logic        rd_word;
    logic        last_word;
    logic [63:0] csr_rdata;

    assign cmd_in      = io_cmd_i;
    assign mem_resp_in = io_resp_i;

    // Only the low byte decodes the CSR; the response echoes the full header anyway.
    assign csr_off   = cmd_in.header.addr[7:0];
    assign cmd_acc   = io_cmd_v_i & ~resp_v_q;
    assign cmd_is_wr = (cmd_in.header.msg_type == e_bedrock_mem_uc_wr)
                     | (cmd_in.header.msg_type == e_bedrock_mem_wr);
    assign busy      = (state_q != e_idle);
    assign start_go  = cmd_acc & cmd_is_wr & (csr_off == csr_start_off_lp) & ~busy;
    assign rd_word   = io_resp_v_i & (state_q == e_wait);
    assign last_word = rd_word & ((idx_q + 64'd1) == len_q);

    assign io_cmd_ready_o = ~resp_v_q;
    assign io_resp_v_o    = resp_v_q;
    assign io_resp_o      = resp_q;
    assign io_cmd_o       = rd_cmd;

    // Header fields of returning read data and the CSR base are not needed by this block.
    logic unused_sink;
    assign unused_sink = ^{csr_base_p, mem_resp_in.header};

    // CSR read mux; status reflects current registers, so a same-cycle completion reads as busy.
    always_comb begin
        csr_rdata = '0;
        case (csr_off)
            csr_base_off_lp:   csr_rdata = base_q;
            csr_len_off_lp:    csr_rdata = len_q;
            csr_status_off_lp: csr_rdata = {62'd0, done_q, busy};
            csr_result_off_lp: csr_rdata = result_q;
            default:           csr_rdata = '0;
        endcase
    end

    // Outgoing uncached 8-byte read for the current vector element.
    always_comb begin
        rd_cmd                       = '0;
        rd_cmd.header.msg_type       = e_bedrock_mem_uc_rd;
        rd_cmd.header.addr           = paddr_width_p'(base_q + (idx_q << 3));
        rd_cmd.header.size           = e_bedrock_msg_size_8;
        rd_cmd.header.payload.lce_id = lce_id_i;
    end

    // Master FSM: next state and handshake outputs; IDLE keeps ready high to drain stale data.
    always_comb begin
        state_d         = state_q;
        io_cmd_v_o      = 1'b0;
        io_resp_ready_o = 1'b0;
        case (state_q)
            e_idle: begin
                io_resp_ready_o = 1'b1;
                if (start_go && (len_q != 64'd0)) begin
                    state_d = e_req;
                end
            end
            e_req: begin
                io_cmd_v_o = 1'b1;
                if (io_cmd_yumi_i) begin
                    state_d = e_wait;
                end
            end
            e_wait: begin
                io_resp_ready_o = 1'b1;
                if (io_resp_v_i) begin
                    state_d = last_word ? e_idle : e_req;
                end
            end
            default: begin
                state_d = e_idle;
            end
        endcase
    end

    // CSR, accumulator and response-register next state; base/len writes are dropped while busy.
    always_comb begin
        base_d   = base_q;
        len_d    = len_q;
        result_d = result_q;
        idx_d    = idx_q;
        done_d   = done_q;
        resp_v_d = resp_v_q;
        resp_d   = resp_q;

        if (cmd_acc && cmd_is_wr && !busy) begin
            if (csr_off == csr_base_off_lp) begin
                base_d = cmd_in.data[63:0];
            end
            if (csr_off == csr_len_off_lp) begin
                len_d = cmd_in.data[63:0];
            end
        end

        if (start_go) begin
            result_d = '0;
            idx_d    = '0;
            done_d   = (len_q == 64'd0);
        end

        if (rd_word) begin
            result_d = result_q + mem_resp_in.data[63:0];
            idx_d    = idx_q + 64'd1;
            if (last_word) begin
                done_d = 1'b1;
            end
        end

        if (resp_v_q && io_resp_yumi_i) begin
            resp_v_d = 1'b0;
        end
        if (cmd_acc) begin
            resp_v_d      = 1'b1;
            resp_d.header = cmd_in.header;
            resp_d.data   = cmd_is_wr ? '0 : cce_block_width_p'(csr_rdata);
        end
    end

    // State registers; reset abandons any run in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_idle;
            base_q   <= '0;
            len_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            resp_v_q <= 1'b0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            resp_v_q <= resp_v_d;
            resp_q   <= resp_d;
        end
    end

endmodule

// File: tb/tb_bp_sacc_vsum.sv
// Bench for bp_sacc_vsum: CSR driver, randomised memory responder and a sum/address model.
// Inputs change and outputs are sampled on the falling clock edge.
// Responder stalls yumi and read data at random when enabled.

module tb_bp_sacc_vsum;
    import bp_sacc_vsum_pkg::*;

    localparam bp_proc_param_s pp = bp_get_proc_param(e_bp_default_cfg);
    localparam int PW  = pp.paddr_width;
    localparam int BW  = pp.cce_block_width;
    localparam int LW  = pp.lce_id_width;
    localparam int WW  = $clog2(pp.lce_assoc);
    localparam int MW  = bp_mem_msg_width(e_bp_default_cfg);
    localparam logic [63:0] PMASK = (64'd1 << PW) - 64'd1;

    localparam logic [7:0] OFF_BASE   = 8'h00;
    localparam logic [7:0] OFF_LEN    = 8'h08;
    localparam logic [7:0] OFF_START  = 8'h10;
    localparam logic [7:0] OFF_STATUS = 8'h18;
    localparam logic [7:0] OFF_RESULT = 8'h20;

    typedef struct packed {
        logic [LW-1:0] lce_id;
        logic [WW-1:0] way_id;
    } payload_s;

    typedef struct packed {
        bp_bedrock_mem_type_e msg_type;
        logic [PW-1:0]        addr;
        bp_bedrock_msg_size_e size;
        payload_s             payload;
    } header_s;

    typedef struct packed {
        header_s       header;
        logic [BW-1:0] data;
    } msg_s;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [LW-1:0] lce_id = 4'h5;
    logic [MW-1:0] io_cmd_i = '0;
    logic          io_cmd_v_i = 1'b0;
    logic          io_cmd_ready_o;
    logic [MW-1:0] io_resp_o;
    logic          io_resp_v_o;
    logic          io_resp_yumi_i = 1'b0;
    logic [MW-1:0] io_cmd_o;
    logic          io_cmd_v_o;
    logic          io_cmd_yumi_i = 1'b0;
    logic [MW-1:0] io_resp_i = '0;
    logic          io_resp_v_i = 1'b0;
    logic          io_resp_ready_o;

    int errors = 0;
    int checks = 0;

    bit          stall_en   = 1'b0;
    bit          stale_mode = 1'b0;
    bit          stale_go   = 1'b0;
    logic [63:0] mem [logic [63:0]];
    logic [63:0] rd_addrs [$];
    logic [63:0] vec_words [$];

    bp_sacc_vsum dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .lce_id_i       (lce_id),
        .io_cmd_i       (io_cmd_i),
        .io_cmd_v_i     (io_cmd_v_i),
        .io_cmd_ready_o (io_cmd_ready_o),
        .io_resp_o      (io_resp_o),
        .io_resp_v_o    (io_resp_v_o),
        .io_resp_yumi_i (io_resp_yumi_i),
        .io_cmd_o       (io_cmd_o),
        .io_cmd_v_o     (io_cmd_v_o),
        .io_cmd_yumi_i  (io_cmd_yumi_i),
        .io_resp_i      (io_resp_i),
        .io_resp_v_i    (io_resp_v_i),
        .io_resp_ready_o(io_resp_ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic msg_s mk_cmd(input bit wr, input logic [7:0] off, input logic [63:0] wdata);
        msg_s m;
        m = '0;
        if (wr) m.header.msg_type = e_bedrock_mem_uc_wr;
        else    m.header.msg_type = e_bedrock_mem_uc_rd;
        m.header.addr           = PW'({$urandom, $urandom});
        m.header.addr[7:0]      = off;
        m.header.size           = e_bedrock_msg_size_8;
        m.header.payload.lce_id = LW'($urandom);
        m.header.payload.way_id = WW'($urandom);
        m.data                  = BW'(wdata);
        return m;
    endfunction

    // Issue one CSR command from a falling edge; returns on a falling edge after the response is consumed.
    task automatic csr_op(input bit wr, input logic [7:0] off, input logic [63:0] wdata,
                          output logic [63:0] rdata);
        msg_s m;
        msg_s r;
        int   n;
        m = mk_cmd(wr, off, wdata);
        io_cmd_i   = m;
        io_cmd_v_i = 1'b1;
        n = 0;
        while (io_cmd_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_ready_timeout", 64'(io_cmd_ready_o), 64'd1);
        @(negedge clk);
        io_cmd_v_i = 1'b0;
        check("resp_v_latency", 64'(io_resp_v_o), 64'd1);
        r = io_resp_o;
        check("resp_hdr_echo", 64'(r.header), 64'(m.header));
        if (wr) check("wr_resp_data", 64'(r.data), 64'd0);
        rdata = 64'(r.data);
        io_resp_yumi_i = 1'b1;
        @(negedge clk);
        io_resp_yumi_i = 1'b0;
    endtask

    task automatic csr_wr(input logic [7:0] off, input logic [63:0] d);
        logic [63:0] dummy;
        csr_op(1'b1, off, d, dummy);
    endtask

    task automatic csr_rd(input logic [7:0] off, output logic [63:0] d);
        csr_op(1'b0, off, 64'd0, d);
    endtask

    // Memory responder on the master port.
    initial begin : responder
        msg_s        c;
        msg_s        m;
        logic [63:0] a;
        logic [63:0] d;
        int          n;
        forever begin
            @(negedge clk);
            if (reset_n && io_cmd_v_o === 1'b1) begin
                if (stall_en) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(negedge clk);
                        check("rd_cmd_v_held", 64'(io_cmd_v_o), 64'd1);
                    end
                end
                c = io_cmd_o;
                check("rd_msg_type", 64'(c.header.msg_type), 64'(e_bedrock_mem_uc_rd));
                check("rd_size", 64'(c.header.size), 64'(e_bedrock_msg_size_8));
                check("rd_lce_id", 64'(c.header.payload.lce_id), 64'(lce_id));
                a = 64'(c.header.addr);
                rd_addrs.push_back(a);
                io_cmd_yumi_i = 1'b1;
                @(negedge clk);
                io_cmd_yumi_i = 1'b0;
                if (stale_mode) begin
                    n = 0;
                    while (!stale_go && n < 500) begin
                        @(negedge clk);
                        n++;
                    end
                    d = 64'hDEAD_BEEF_0000_0001;
                end else begin
                    if (stall_en) repeat ($urandom_range(0, 3)) @(negedge clk);
                    d = mem.exists(a) ? mem[a] : 64'd0;
                end
                m = '0;
                m.data = BW'(d);
                io_resp_i   = m;
                io_resp_v_i = 1'b1;
                n = 0;
                while (io_resp_ready_o !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) check("rd_resp_ready_timeout", 64'(io_resp_ready_o), 64'd1);
                @(negedge clk);
                io_resp_v_i = 1'b0;
            end
        end
    end

    // Run one vector of vec_words from base and compare against the plain sum and address list.
    task automatic run_vec(input string tag, input logic [63:0] base, input int n, input bit extra_writes);
        logic [63:0] exp_sum;
        logic [63:0] s;
        logic [63:0] a;
        int          polls;
        mem.delete();
        rd_addrs.delete();
        exp_sum = 64'd0;
        for (int i = 0; i < n; i++) begin
            a = (base + 64'(8 * i)) & PMASK;
            mem[a] = vec_words[i];
            exp_sum = exp_sum + vec_words[i];
        end
        csr_wr(OFF_BASE, base);
        csr_wr(OFF_LEN, 64'(n));
        csr_wr(OFF_START, {$urandom, $urandom});
        csr_rd(OFF_STATUS, s);
        check($sformatf("%s_status_after_start", tag), s, (n == 0) ? 64'd2 : 64'd1);
        if (extra_writes) begin
            csr_wr(OFF_START, 64'd1);
            csr_wr(OFF_LEN, 64'd9);
        end
        polls = 0;
        s = 64'd0;
        while (s[1] !== 1'b1 && polls < 80) begin
            csr_rd(OFF_STATUS, s);
            polls++;
        end
        check($sformatf("%s_status_done", tag), s, 64'd2);
        csr_rd(OFF_RESULT, s);
        check($sformatf("%s_result", tag), s, exp_sum);
        repeat (4) @(negedge clk);
        check($sformatf("%s_read_count", tag), 64'(rd_addrs.size()), 64'(n));
        for (int i = 0; i < n && i < rd_addrs.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), rd_addrs[i], (base + 64'(8 * i)) & PMASK);
        end
        csr_rd(OFF_LEN, s);
        check($sformatf("%s_len_readback", tag), s, 64'(n));
        csr_rd(OFF_BASE, s);
        check($sformatf("%s_base_readback", tag), s, base);
    endtask

    initial begin : main
        logic [63:0] s;
        msg_s        mb;
        msg_s        r;
        int          n;
        int          len;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(io_cmd_ready_o), 64'd1);
        check("rst_resp_v", 64'(io_resp_v_o), 64'd0);
        check("rst_cmd_v", 64'(io_cmd_v_o), 64'd0);
        check("rst_resp_ready", 64'(io_resp_ready_o), 64'd1);
        reset_n = 1'b1;
        @(negedge clk);

        csr_rd(OFF_BASE, s);   check("rst_base", s, 64'd0);
        csr_rd(OFF_LEN, s);    check("rst_len", s, 64'd0);
        csr_rd(OFF_STATUS, s); check("rst_status", s, 64'd0);
        csr_rd(OFF_RESULT, s); check("rst_result", s, 64'd0);

        csr_rd(8'h28, s);      check("unmapped_rd", s, 64'd0);
        csr_wr(8'h30, 64'h1234);
        csr_rd(8'h30, s);      check("unmapped_wr_dropped", s, 64'd0);

        // Basic four-word run.
        vec_words = '{64'd1, 64'd2, 64'd3, 64'd4};
        run_vec("basic", 64'h8000, 4, 1'b0);

        // Zero-length run completes immediately with no reads.
        run_vec("len0", 64'h1000, 0, 1'b0);

        // Accumulator wraps modulo 2^64.
        vec_words = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
        run_vec("wrap", 64'h2000, 2, 1'b0);

        // start and len writes during a run are acknowledged and ignored.
        stall_en = 1'b1;
        vec_words = '{64'd5, 64'd6, 64'd7};
        run_vec("midrun", 64'h3000, 3, 1'b1);

        // Response held without yumi: no new command is taken and the response stays put.
        csr_wr(OFF_BASE, 64'h1234_5678);
        io_cmd_i   = mk_cmd(1'b0, OFF_BASE, 64'd0);
        io_cmd_v_i = 1'b1;
        n = 0;
        while (io_cmd_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        mb = mk_cmd(1'b0, OFF_LEN, 64'd0);
        io_cmd_i = mb;
        for (int i = 0; i < 5; i++) begin
            r = io_resp_o;
            check($sformatf("hold_ready%0d", i), 64'(io_cmd_ready_o), 64'd0);
            check($sformatf("hold_resp_v%0d", i), 64'(io_resp_v_o), 64'd1);
            check($sformatf("hold_resp_data%0d", i), 64'(r.data), 64'h1234_5678);
            @(negedge clk);
        end
        io_resp_yumi_i = 1'b1;
        @(negedge clk);
        io_resp_yumi_i = 1'b0;
        n = 0;
        while (io_cmd_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        io_cmd_v_i = 1'b0;
        r = io_resp_o;
        check("hold_second_resp_v", 64'(io_resp_v_o), 64'd1);
        check("hold_second_hdr", 64'(r.header), 64'(mb.header));
        check("hold_second_data", 64'(r.data), 64'd3);
        io_resp_yumi_i = 1'b1;
        @(negedge clk);
        io_resp_yumi_i = 1'b0;

        // Random vectors with random stalls.
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 8);
            vec_words.delete();
            for (int i = 0; i < len; i++) vec_words.push_back({$urandom, $urandom});
            run_vec($sformatf("rand%0d", t), {$urandom, $urandom}, len, 1'b0);
        end

        // Reset in WAIT, then deliver the stale read data into IDLE.
        stall_en   = 1'b0;
        stale_mode = 1'b1;
        stale_go   = 1'b0;
        rd_addrs.delete();
        csr_wr(OFF_BASE, 64'h4000);
        csr_wr(OFF_LEN, 64'd4);
        csr_wr(OFF_START, 64'd1);
        n = 0;
        while (rd_addrs.size() < 1 && n < 100) begin @(negedge clk); n++; end
        check("rstrun_first_read", 64'(rd_addrs.size()), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("rstrun_cmd_v", 64'(io_cmd_v_o), 64'd0);
        check("rstrun_resp_ready", 64'(io_resp_ready_o), 64'd1);
        check("rstrun_cmd_ready", 64'(io_cmd_ready_o), 64'd1);
        reset_n  = 1'b1;
        stale_go = 1'b1;
        repeat (12) @(negedge clk);
        check("rstrun_no_more_reads", 64'(rd_addrs.size()), 64'd1);
        stale_mode = 1'b0;
        stale_go   = 1'b0;
        csr_rd(OFF_STATUS, s); check("rstrun_status", s, 64'd0);
        csr_rd(OFF_RESULT, s); check("rstrun_result", s, 64'd0);
        csr_rd(OFF_BASE, s);   check("rstrun_base", s, 64'd0);
        csr_rd(OFF_LEN, s);    check("rstrun_len", s, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not reach the end, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
